// File: rtl/alu_pkg.sv
// Shared ALU op encodings, flag layout and op-class helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_PASS_B   = 3'b000,
        ALU_ADD      = 3'b010,
        ALU_SUBTRACT = 3'b011,
        ALU_AND      = 3'b100,
        ALU_OR       = 3'b101,
        ALU_XOR      = 3'b110
    } alu_op_t;

    typedef struct packed {
        logic negative;
        logic zero;
        logic overflow;
        logic carry_out;
    } alu_flags_t;

    function automatic logic is_arith(alu_op_t op);
        return (op == ALU_ADD) || (op == ALU_SUBTRACT);
    endfunction

    function automatic logic is_unused_op(logic [2:0] cntrl);
        return (cntrl == 3'b001) || (cntrl == 3'b111);
    endfunction

endpackage

// File: rtl/alu.sv
// 64-bit combinational ALU: PASS_B / ADD / SUBTRACT / AND / OR / XOR.
// Latency: purely combinational, full cycle allotted by the surrounding registers.
// Backpressure: none.
module alu (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [2:0]  cntrl,
    output logic [63:0] result,
    output logic        carry_out,
    output logic        overflow
);

    logic        sub;
    logic [63:0] b_eff;
    logic [64:0] sum_ext;

    always_comb begin
        sub       = (cntrl == 3'b011);
        b_eff     = sub ? ~b : b;
        sum_ext   = {1'b0, a} + {1'b0, b_eff} + {64'd0, sub};
        carry_out = sum_ext[64];
        // Signed overflow: operands agree in sign but the sum does not.
        overflow  = (a[63] == b_eff[63]) && (sum_ext[63] != a[63]);
        case (cntrl)
            3'b000:  result = b;
            3'b010:  result = sum_ext[63:0];
            3'b011:  result = sum_ext[63:0];
            3'b100:  result = a & b;
            3'b101:  result = a | b;
            3'b110:  result = a ^ b;
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant over NREQ requests, searching from last_grant+1.
// Latency: grant is combinational; pointer updates on the edge where advance is high.
// Backpressure: requests not granted simply stay pending.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic              advance,
    output logic [NREQ-1:0]   grant,
    output logic [IDX_W-1:0]  grant_idx
);

    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDX_W'((int'(last_grant_q) + off) % NREQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
        last_grant_d = (advance && found) ? grant_idx : last_grant_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= IDX_W'(NREQ - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin sharing of one ALU among NREQ requesters; ALU_ARB_ILLEGAL_OP_EN adds rsp_err.
// Latency: accept at edge N, registered response valid after edge N+1; one op per 3 cycles.
// Backpressure: response held in DONE until rsp_ready; no grants while an op is in flight.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0][63:0]  req_a,
    input  logic [NREQ-1:0][63:0]  req_b,
    input  logic [NREQ-1:0][2:0]   req_cntrl,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [63:0]            rsp_result,
`ifdef ALU_ARB_ILLEGAL_OP_EN
    output logic                   rsp_err,
`endif
    output logic [3:0]             rsp_flags
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [63:0]      a_q, a_d, b_q, b_d;
    logic [2:0]       cntrl_q, cntrl_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [63:0]      rsp_result_q, rsp_result_d;
    alu_flags_t       rsp_flags_q, rsp_flags_d;

    logic [NREQ-1:0]  grant;
    logic [ID_W-1:0]  grant_idx;
    logic             accept;

    logic [2:0]       alu_cntrl;
    logic [63:0]      alu_b;
    logic [63:0]      alu_result;
    logic             alu_carry, alu_ovf;
    alu_flags_t       flags_next;

`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic             rsp_err_q, rsp_err_d;
    logic             op_illegal;
`endif

    rr_arbiter #(.NREQ(NREQ), .IDX_W(ID_W)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = (state_q == ST_IDLE) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
`ifdef ALU_ARB_ILLEGAL_OP_EN
        // Unused encodings become PASS_B of zero so the response is a clean 0.
        op_illegal = is_unused_op(cntrl_q);
        alu_cntrl  = op_illegal ? ALU_PASS_B : cntrl_q;
        alu_b      = op_illegal ? 64'd0 : b_q;
`else
        alu_cntrl  = cntrl_q;
        alu_b      = b_q;
`endif
    end

    alu u_alu (
        .a         (a_q),
        .b         (alu_b),
        .cntrl     (alu_cntrl),
        .result    (alu_result),
        .carry_out (alu_carry),
        .overflow  (alu_ovf)
    );

    always_comb begin
        flags_next.negative  = alu_result[63];
        flags_next.zero      = (alu_result == 64'd0);
        flags_next.overflow  = is_arith(alu_op_t'(alu_cntrl)) && alu_ovf;
        flags_next.carry_out = is_arith(alu_op_t'(alu_cntrl)) && alu_carry;
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        cntrl_d      = cntrl_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        rsp_err_d    = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = req_a[grant_idx];
                    b_d     = req_b[grant_idx];
                    cntrl_d = req_cntrl[grant_idx];
                    id_d    = grant_idx;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_valid_d  = 1'b1;
                rsp_id_d     = id_q;
                rsp_result_d = alu_result;
                rsp_flags_d  = flags_next;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                rsp_err_d    = op_illegal;
`endif
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            cntrl_q      <= '0;
            id_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cntrl_q      <= cntrl_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign rsp_err    = rsp_err_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a response scoreboard fed at accept time.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_alu_rr_arbiter;
    import alu_pkg::*;

    localparam int NREQ = 2;
    localparam int ID_W = 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][63:0] req_a;
    logic [NREQ-1:0][63:0] req_b;
    logic [NREQ-1:0][2:0]  req_cntrl;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [63:0]           rsp_result;
    logic [3:0]            rsp_flags;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic                  rsp_err;
`endif

    always #5 clk = ~clk;

    alu_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cntrl  (req_cntrl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
`ifdef ALU_ARB_ILLEGAL_OP_EN
        .rsp_err    (rsp_err),
`endif
        .rsp_flags  (rsp_flags)
    );

    typedef struct {
        logic [ID_W-1:0] id;
        logic [63:0]     res;
        logic [3:0]      flags;
        logic            err;
    } exp_t;

    exp_t sb[$];
    int   acc_id[$];
    int   acc_cyc[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_rsp = 0;
    int   last_rsp_cyc = -1;
    logic [63:0]     last_res;
    logic [3:0]      last_flags;
    logic [ID_W-1:0] last_id;

    function automatic exp_t model(int id, logic [2:0] c, logic [63:0] a, logic [63:0] b);
        exp_t e;
        logic [63:0] r;
        logic ov, cy, err;
        r = 64'd0; ov = 1'b0; cy = 1'b0; err = 1'b0;
        case (c)
            3'b000: r = b;
            3'b010: begin
                r  = a + b;
                cy = (r < a);
                ov = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'b011: begin
                r  = a - b;
                cy = (a >= b);
                ov = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: begin
                r = 64'd0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                err = 1'b1;
`endif
            end
        endcase
        e.id    = ID_W'(id);
        e.res   = r;
        e.flags = {r[63], (r == 64'd0), ov, cy};
        e.err   = err;
        return e;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                sb.push_back(model(i, req_cntrl[i], req_a[i], req_b[i]));
                acc_id.push_back(i);
                acc_cyc.push_back(cyc);
            end
        end
        if (rsp_valid && rsp_ready) begin
            check("rsp_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_result", rsp_result, e.res);
                check("rsp_flags", 64'(rsp_flags), 64'(e.flags));
`ifdef ALU_ARB_ILLEGAL_OP_EN
                check("rsp_err", 64'(rsp_err), 64'(e.err));
`endif
            end
            last_res     = rsp_result;
            last_flags   = rsp_flags;
            last_id      = rsp_id;
            last_rsp_cyc = cyc;
            n_rsp++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(string tag);
        int n0 = acc_id.size();
        int k = 0;
        while (acc_id.size() == n0 && k < 20) begin tick(); k++; end
        check(tag, 64'(acc_id.size() > n0), 64'd1);
    endtask

    task automatic wait_rsp(string tag);
        int r0 = n_rsp;
        int k = 0;
        while (n_rsp == r0 && k < 20) begin tick(); k++; end
        check(tag, 64'(n_rsp > r0), 64'd1);
    endtask

    task automatic do_op(int id, logic [2:0] c, logic [63:0] a, logic [63:0] b);
        req_a[id] = a; req_b[id] = b; req_cntrl[id] = c; req_valid[id] = 1'b1;
        wait_accept("op_accept_timeout");
        req_valid[id] = 1'b0;
        wait_rsp("op_rsp_timeout");
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin tick(); k++; end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, g;
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cntrl = '0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        tick(); tick();
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_result", rsp_result, 64'd0);
        check("reset_rsp_flags", 64'(rsp_flags), 64'd0);
        check("reset_rsp_id", 64'(rsp_id), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        reset = 1'b0;
        tick();

        // 1: single ADD, response two cycles after the accept
        do_op(0, 3'b010, 64'd5, 64'd3);
        check("t1_result", last_res, 64'd8);
        check("t1_id", 64'(last_id), 64'd0);
        check("t1_flags", 64'(last_flags), 64'h0);
        check("t1_latency", 64'(last_rsp_cyc - acc_cyc[acc_cyc.size()-1]), 64'd2);

        // 2: two continuous requesters alternate, one accept per 3 cycles
        req_a[0] = 64'd100; req_b[0] = 64'd1; req_cntrl[0] = 3'b010;
        req_a[1] = 64'hF0;  req_b[1] = 64'h0F; req_cntrl[1] = 3'b101;
        req_valid = 2'b11;
        n0 = acc_id.size();
        for (int k = 0; k < 13; k++) tick();
        req_valid = 2'b00;
        drain();
        check("t2_count", 64'(acc_id.size() - n0), 64'd5);
        check("t2_first", 64'(acc_id[n0]), 64'd1);
        for (int k = n0 + 1; k < acc_id.size(); k++) begin
            check("t2_alternate", 64'(acc_id[k]), 64'(1 - acc_id[k-1]));
            check("t2_spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd3);
        end

        // 3: SUBTRACT going negative
        do_op(1, 3'b011, 64'd3, 64'd5);
        check("t3_result", last_res, 64'hFFFF_FFFF_FFFF_FFFE);
        check("t3_flags", 64'(last_flags), 64'b1000);

        // 4: signed overflow on ADD, then XOR to zero
        do_op(0, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        check("t4_add_result", last_res, 64'h8000_0000_0000_0000);
        check("t4_add_flags", 64'(last_flags), 64'b1010);
        do_op(1, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t4_xor_result", last_res, 64'd0);
        check("t4_xor_flags", 64'(last_flags), 64'b0100);

        // 5: response stalled for 5 cycles
        rsp_ready = 1'b0;
        req_a[0] = 64'd10; req_b[0] = 64'd20; req_cntrl[0] = 3'b010;
        req_a[1] = 64'hFF00; req_b[1] = 64'h0FF0; req_cntrl[1] = 3'b100;
        req_valid = 2'b11;
        begin
            int k = 0;
            while (!rsp_valid && k < 20) begin tick(); k++; end
        end
        check("t5_rsp_valid", 64'(rsp_valid), 64'd1);
        g = acc_id[acc_id.size()-1];
        check("t5_grant", 64'(g), 64'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t5_hold_valid", 64'(rsp_valid), 64'd1);
            check("t5_hold_result", rsp_result, sb[0].res);
            check("t5_hold_id", 64'(rsp_id), 64'(sb[0].id));
            check("t5_hold_flags", 64'(rsp_flags), 64'(sb[0].flags));
            check("t5_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("t5_no_grant_in_done", 64'(req_ready), 64'd0);
        tick();
        check("t5_rsp_cleared", 64'(rsp_valid), 64'd0);
        wait_accept("t5_next_accept");
        check("t5_next_grant", 64'(acc_id[acc_id.size()-1]), 64'(1 - g));
        req_valid = 2'b00;
        drain();

        // 6: reset during EXEC abandons the op and restores the pointer
        req_a[0] = 64'd7; req_b[0] = 64'd1; req_cntrl[0] = 3'b011;
        req_valid[0] = 1'b1;
        wait_accept("t6_accept");
        req_valid[0] = 1'b0;
        reset = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0;
        check("t6_rsp_valid_after_reset", 64'(rsp_valid), 64'd0);
        check("t6_result_after_reset", rsp_result, 64'd0);
        check("t6_flags_after_reset", 64'(rsp_flags), 64'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t6_no_rsp", 64'(rsp_valid), 64'd0);
        end
        req_a[1] = 64'd1; req_b[1] = 64'd2; req_cntrl[1] = 3'b000;
        req_valid = 2'b11;
        #1;
        check("t6_first_grant", 64'(req_ready), 64'b01);
        wait_accept("t6_post_accept");
        check("t6_first_id", 64'(acc_id[acc_id.size()-1]), 64'd0);
        req_valid = 2'b00;
        drain();

`ifdef ALU_ARB_ILLEGAL_OP_EN
        do_op(1, 3'b111, 64'd9, 64'd9);
        check("ill_result", last_res, 64'd0);
        check("ill_flags", 64'(last_flags), 64'b0100);
        check("ill_err", 64'(rsp_err), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares one 64-bit `alu` instance (cntrl encodings PASS_B/ADD/SUBTRACT/AND/OR/XOR) between NREQ requesters.
- Round-robin arbitration over valid/ready request ports.
- Operands registered before the ALU; result and flags registered after it, so the ripple ALU gets a full cycle.
- One tagged response port returns result, flags and requester id.
- Sits between the issue logic and the shared ALU datapath.

Parameters:
- NREQ, 2, number of requesters (legal range 2..4).
- ID_W, $clog2(NREQ), width of the response id.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  [NREQ-1:0]  per-requester operation valid.
- req_ready  out  [NREQ-1:0]  one-hot grant; accept occurs when req_valid[i] && req_ready[i].
- req_a  in  [NREQ-1:0][63:0]  operand A per requester.
- req_b  in  [NREQ-1:0][63:0]  operand B per requester.
- req_cntrl  in  [NREQ-1:0][2:0]  ALU op per requester.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_result  out  64  ALU result.
- rsp_flags  out  4  {negative, zero, overflow, carry_out}.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - rr pointer (last_grant) is NREQ-1, so requester 0 has priority first.
- FSM states:
  - IDLE: req_ready is the one-hot grant of the highest-priority valid requester, searching from last_grant+1 with wrap-around. It is combinational from state, pointer and req_valid. If no requester is valid, req_ready is 0.
    - On accept: capture a, b, cntrl and the grant index into operand registers, set last_grant to that index, go to EXEC.
  - EXEC: exactly one cycle; req_ready is 0 and the ALU evaluates the registered operands. At the clock edge, capture the ALU result and flags into the output registers, set rsp_valid=1, go to DONE.
  - DONE: rsp_* are held stable while rsp_ready=0. On rsp_valid && rsp_ready, rsp_valid clears and the FSM goes to IDLE. No new grant is issued in the same cycle.
- Latency and throughput:
  - Accept at edge N; rsp_valid is high in the cycle after edge N+1.
  - Peak throughput is one operation per 3 cycles.
- Flags:
  - negative = result[63]; zero = (result == 0).
  - overflow and carry_out are taken from the ALU for ADD and SUBTRACT only, and forced to 0 for all other ops.
- A requester that is not granted must hold its request. The block never drops an accepted operation.
- Reset asserted in any state (including EXEC or DONE) abandons the in-flight operation: no response is produced, and all state, pointer and outputs return to reset values on that edge.
- Unused encodings (001, 111) are forwarded to the ALU unchanged unless the optional feature below is enabled.

Optional Feature:
ALU_ARB_ILLEGAL_OP_EN
- Defined:
  - Adds output port rsp_err (1 bit, reset 0).
  - cntrl 001 or 111 is still accepted, but the ALU is driven with PASS_B and B=0.
  - The response carries result 0, flags 4'b0100 and rsp_err=1.
  - Legal ops return rsp_err=0.
- Undefined: no rsp_err port; the cntrl value is passed through unchanged and the result is whatever the ALU produces.

Decomposition:
- Package alu_pkg contains:
  - alu_op_t enum (ALU_PASS_B=3'b000, ALU_ADD=3'b010, ALU_SUBTRACT=3'b011, ALU_AND=3'b100, ALU_OR=3'b101, ALU_XOR=3'b110).
  - alu_flags_t packed struct {negative, zero, overflow, carry_out}.
  - Function is_arith(alu_op_t).
- Sub-module rr_arbiter (parameter NREQ):
  - Inputs: req, advance.
  - Outputs: one-hot grant and grant index.
  - Owns the last_grant pointer.
- The existing alu is instantiated unchanged.

Test Plan:
1. Requester 0 only: ADD, A=5, B=3 → rsp_result=8, rsp_id=0, rsp_flags=4'b0000; rsp_valid asserts 2 cycles after accept.
2. Requesters 0 and 1 both valid continuously, rsp_ready=1 → grants alternate 0,1,0,1 and rsp_id follows; one accept every 3 cycles.
3. SUBTRACT, A=3, B=5 → rsp_result=64'hFFFF_FFFF_FFFF_FFFE, negative=1, zero=0, overflow=0, carry_out=0.
4. ADD, A=64'h7FFF_FFFF_FFFF_FFFF, B=1 → rsp_result=64'h8000_0000_0000_0000, negative=1, overflow=1, carry_out=0. Then XOR, A=B=64'hFFFF_FFFF_FFFF_FFFF → result 0, flags 4'b0100.
5. rsp_ready held 0 for 5 cycles in DONE → rsp_* stable and req_ready=0 throughout; on the handshake the next grant goes to the other requester.
6. reset pulsed during EXEC → no response ever appears; after reset, requesters 0 and 1 both valid → requester 0 is granted first.
